marie_control_unit: RTL and testbench

// - Multi-cycle fetch/decode/execute sequencer for the 16-bit accumulator CPU.
// - Owns PC, IR, MAR, MBR and AC.
// - Drives the single-port sync RAM (cs/we/oe) and the combinational ALU.
// - Replaces bench-driven sequencing; sits between top-level start/halt control, the RAM and the ALU.

---
 rtl/marie_pkg.sv | 37 +++
 rtl/marie_skip_eval.sv | 29 ++
 rtl/marie_control_unit.sv | 165 ++++++++++++++++
 tb/tb_marie_control_unit.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/marie_pkg.sv
// Shared types and encodings for the MARIE accumulator CPU sequencer.
package marie_pkg;

    typedef enum logic [3:0] {
        OP_LOAD     = 4'h1,
        OP_STORE    = 4'h2,
        OP_ADD      = 4'h3,
        OP_SUBT     = 4'h4,
        OP_HALT     = 4'h7,
        OP_SKIPCOND = 4'h8,
        OP_JUMP     = 4'h9,
        OP_CLEAR    = 4'hA
    } opcode_e;

    typedef enum logic [3:0] {
        IDLE,
        F0,
        F1,
        D,
        M0,
        M1,
        X,
        W0,
        W1,
        HALTED
    } state_e;

    localparam logic [3:0] ALU_SEL_NOP = 4'h0;
    localparam logic [3:0] ALU_SEL_ADD = 4'h1;
    localparam logic [3:0] ALU_SEL_SUB = 4'h2;

    localparam logic [1:0] SKIP_LT    = 2'b00;
    localparam logic [1:0] SKIP_EQ    = 2'b01;
    localparam logic [1:0] SKIP_GT    = 2'b10;
    localparam logic [1:0] SKIP_NEVER = 2'b11;

endpackage

// File: rtl/marie_skip_eval.sv
// SKIPCOND condition evaluation: signed compare of AC against zero.
module marie_skip_eval
    import marie_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0] ac,
    input  logic [1:0]            cond,
    output logic                  skip
);

    logic ac_neg;
    logic ac_zero;

    assign ac_neg  = ac[DATA_WIDTH-1];
    assign ac_zero = (ac == '0);

    always_comb begin
        skip = 1'b0;
        case (cond)
            SKIP_LT:    skip = ac_neg;
            SKIP_EQ:    skip = ac_zero;
            SKIP_GT:    skip = !ac_neg && !ac_zero;
            SKIP_NEVER: skip = 1'b0;
            default:    skip = 1'b0;
        endcase
    end

endmodule

// File: rtl/marie_control_unit.sv
// Multi-cycle fetch/decode/execute sequencer owning PC, IR, MAR, MBR and AC.
//   state  | meaning
//   IDLE   | waiting for start
//   F0     | fetch request at PC
//   F1     | latch IR, PC+1
//   D      | decode; SKIPCOND/JUMP/CLEAR/undefined finish here
//   M0/M1  | operand read request / latch MBR
//   X      | AC update for LOAD/ADD/SUBT
//   W0/W1  | stage MBR/MAR / single write cycle
//   HALTED | absorbing until reset
module marie_control_unit
    import marie_pkg::*;
#(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 12,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [3:0]            alu_sel,
    input  logic [DATA_WIDTH-1:0] alu_out,
    output logic                  halted,
    output logic                  illegal_op,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] ac,
    output logic [DATA_WIDTH-1:0] ir
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] mar_q, mar_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d;
    logic [DATA_WIDTH-1:0] mbr_q, mbr_d;
    logic [DATA_WIDTH-1:0] ac_q, ac_d;

    logic [3:0]            opcode;
    logic [ADDR_WIDTH-1:0] operand;
    logic                  skip;

    assign opcode  = ir_q[DATA_WIDTH-1 -: 4];
    assign operand = ir_q[ADDR_WIDTH-1:0];

    marie_skip_eval #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skip_eval (
        .ac  (ac_q),
        .cond(ir_q[DATA_WIDTH-5 -: 2]),
        .skip(skip)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mar_d      = mar_q;
        ir_d       = ir_q;
        mbr_d      = mbr_q;
        ac_d       = ac_q;
        mem_cs     = 1'b0;
        mem_we     = 1'b0;
        mem_oe     = 1'b0;
        alu_sel    = ALU_SEL_NOP;
        illegal_op = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) state_d = F0;
            end
            F0: begin
                mar_d   = pc_q;
                mem_cs  = 1'b1;
                mem_oe  = 1'b1;
                state_d = F1;
            end
            F1: begin
                ir_d    = mem_rdata;
                pc_d    = pc_q + ADDR_WIDTH'(1);
                state_d = D;
            end
            D: begin
                state_d = F0;
                case (opcode)
                    OP_LOAD, OP_ADD, OP_SUBT: state_d = M0;
                    OP_STORE:                 state_d = W0;
                    OP_HALT:                  state_d = HALTED;
                    OP_SKIPCOND: begin
                        if (skip) pc_d = pc_q + ADDR_WIDTH'(1);
                    end
                    OP_JUMP:                  pc_d = operand;
                    OP_CLEAR:                 ac_d = '0;
                    default:                  illegal_op = 1'b1;
                endcase
            end
            M0: begin
                mar_d   = operand;
                mem_cs  = 1'b1;
                mem_oe  = 1'b1;
                state_d = M1;
            end
            M1: begin
                mbr_d   = mem_rdata;
                state_d = X;
            end
            X: begin
                if (opcode == OP_LOAD) begin
                    ac_d = mbr_q;
                end else begin
                    alu_sel = (opcode == OP_ADD) ? ALU_SEL_ADD : ALU_SEL_SUB;
                    ac_d    = alu_out;
                end
                state_d = F0;
            end
            W0: begin
                mbr_d   = ac_q;
                mar_d   = operand;
                state_d = W1;
            end
            W1: begin
                mem_cs  = 1'b1;
                mem_we  = 1'b1;
                state_d = F0;
            end
            HALTED: state_d = HALTED;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            mar_q   <= '0;
            ir_q    <= '0;
            mbr_q   <= '0;
            ac_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            mar_q   <= mar_d;
            ir_q    <= ir_d;
            mbr_q   <= mbr_d;
            ac_q    <= ac_d;
        end
    end

    // The sync RAM samples its address on the same edge that closes F0/M0,
    // so the bus carries the value MAR is being loaded with, not the old one.
    assign mem_addr  = mar_d;
    assign mem_wdata = mbr_q;
    assign alu_a     = ac_q;
    assign alu_b     = mbr_q;
    assign halted    = (state_q == HALTED);
    assign pc        = pc_q;
    assign ac        = ac_q;
    assign ir        = ir_q;

endmodule

// File: tb/tb_marie_control_unit.sv
// Directed programs against an instruction-level model of the accumulator CPU.
module tb_marie_control_unit;

    localparam int DW = 16;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_cs, mem_we, mem_oe;
    logic [DW-1:0] alu_a, alu_b, alu_out;
    logic [3:0]    alu_sel;
    logic          halted, illegal_op;
    logic [AW-1:0] pc;
    logic [DW-1:0] ac, ir;

    marie_control_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESET_PC(12'h000)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
        .halted(halted), .illegal_op(illegal_op), .pc(pc), .ac(ac), .ir(ir)
    );

    assign alu_out = (alu_sel == 4'h1) ? alu_a + alu_b :
                     (alu_sel == 4'h2) ? alu_a - alu_b : '0;

    always #5 clk = ~clk;

    logic [DW-1:0] ram   [4096];
    logic [DW-1:0] m_mem [4096];
    logic [AW-1:0] m_pc;
    logic [DW-1:0] m_ac;
    bit            m_halted;
    bit            mon_on;
    int            k, retired;
    int            n_chk = 0, n_fail = 0;
    int            we_cnt, illegal_cnt;
    logic [AW-1:0] last_waddr;
    logic [DW-1:0] last_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lat(input logic [3:0] op);
        if (op == 4'h1 || op == 4'h3 || op == 4'h4) return 6;
        if (op == 4'h2) return 5;
        return 3;
    endfunction

    task automatic model_step(input logic [DW-1:0] instr);
        logic [3:0]    op;
        logic [AW-1:0] a, npc;
        logic [1:0]    cond;
        bit            sk;
        op   = instr[15:12];
        a    = instr[11:0];
        cond = instr[11:10];
        npc  = m_pc + 12'd1;
        case (op)
            4'h1: m_ac = m_mem[a];
            4'h2: m_mem[a] = m_ac;
            4'h3: m_ac = m_ac + m_mem[a];
            4'h4: m_ac = m_ac - m_mem[a];
            4'h7: m_halted = 1'b1;
            4'h8: begin
                sk = (cond == 2'd0) ? ($signed(m_ac) < 0) :
                     (cond == 2'd1) ? (m_ac == 16'd0) :
                     (cond == 2'd2) ? ($signed(m_ac) > 0) : 1'b0;
                if (sk) npc = npc + 12'd1;
            end
            4'h9: npc = a;
            4'hA: m_ac = '0;
            default: ;
        endcase
        m_pc = npc;
        retired++;
    endtask

    // One clock: check at negedge, then service the RAM just after posedge.
    task automatic cycle();
        logic [DW-1:0] instr;
        logic [3:0]    op;
        logic [AW-1:0] a;
        bit            memop, legal, exp_cs, exp_we, req_rd, req_wr;
        logic [AW-1:0] req_addr;
        logic [DW-1:0] req_data;
        int            l;
        @(negedge clk);
        if (illegal_op) illegal_cnt++;
        req_rd   = mem_cs && mem_oe && !mem_we;
        req_wr   = mem_cs && mem_we;
        req_addr = mem_addr;
        req_data = mem_wdata;
        if (mon_on) begin
            if (m_halted) begin
                chk("halted", 32'(halted), 32'd1);
                chk("halt_cs", 32'(mem_cs), 32'd0);
                chk("halt_we", 32'(mem_we), 32'd0);
                chk("halt_pc", 32'(pc), 32'(m_pc));
            end else begin
                instr  = m_mem[m_pc];
                op     = instr[15:12];
                a      = instr[11:0];
                l      = lat(op);
                memop  = (op == 4'h1 || op == 4'h3 || op == 4'h4);
                legal  = memop || op inside {4'h2, 4'h7, 4'h8, 4'h9, 4'hA};
                exp_we = (op == 4'h2) && (k == 5);
                exp_cs = (k == 1) || (memop && k == 4) || exp_we;
                chk("mem_cs", 32'(mem_cs), 32'(exp_cs));
                chk("mem_we", 32'(mem_we), 32'(exp_we));
                if (exp_cs) chk("mem_oe", 32'(mem_oe), 32'(!exp_we));
                if (k == 1) begin
                    chk("pc_fetch", 32'(pc), 32'(m_pc));
                    chk("addr_fetch", 32'(mem_addr), 32'(m_pc));
                end
                if ((memop && k == 4) || exp_we) chk("addr_oper", 32'(mem_addr), 32'(a));
                if (exp_we) chk("wdata", 32'(mem_wdata), 32'(m_ac));
                chk("illegal_op", 32'(illegal_op), 32'(k == 3 && !legal));
                if (k == 3) chk("ir", 32'(ir), 32'(instr));
                chk("ac", 32'(ac), 32'(m_ac));
                chk("alu_a", 32'(alu_a), 32'(m_ac));
                chk("halted_lo", 32'(halted), 32'd0);
                if (memop && k == 6) begin
                    chk("alu_sel", 32'(alu_sel), (op == 4'h3) ? 32'd1 : (op == 4'h4) ? 32'd2 : 32'd0);
                    chk("alu_b", 32'(alu_b), 32'(m_mem[a]));
                end
                if (k == l) begin
                    model_step(instr);
                    k = 1;
                end else begin
                    k++;
                end
            end
        end
        @(posedge clk);
        #1;
        if (req_wr) begin
            ram[req_addr] = req_data;
            we_cnt++;
            last_waddr = req_addr;
            last_wdata = req_data;
        end
        if (req_rd) mem_rdata = ram[req_addr];
    endtask

    task automatic do_reset();
        mon_on = 1'b0;
        start  = 1'b0;
        rst_n  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        we_cnt = 0;
        illegal_cnt = 0;
        for (int i = 0; i < 4096; i++) begin
            ram[i]   = '0;
            m_mem[i] = '0;
        end
    endtask

    task automatic put(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        ram[addr]   = data;
        m_mem[addr] = data;
    endtask

    task automatic go();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        m_pc = 12'h000;
        m_ac = '0;
        m_halted = 1'b0;
        k = 1;
        retired = 0;
        mon_on = 1'b1;
    endtask

    task automatic run_until(input int target, input int budget);
        int used;
        used = 0;
        while (!m_halted && retired < target && used < budget) begin
            cycle();
            used++;
        end
        chk("run_timeout", 32'(!m_halted && retired < target), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state
        do_reset();
        chk("rst_pc", 32'(pc), 32'h000);
        chk("rst_ac", 32'(ac), 32'h0);
        chk("rst_ir", 32'(ir), 32'h0);
        chk("rst_cs", 32'(mem_cs), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'h0);
        chk("rst_halted", 32'(halted), 32'd0);

        // Reset during M1 of a LOAD
        put(12'h000, 16'h100C);
        put(12'h001, 16'h7000);
        put(12'h00C, 16'h0007);
        go();
        repeat (4) cycle();
        mon_on = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("midrst_pc", 32'(pc), 32'h000);
        chk("midrst_ir", 32'(ir), 32'h0);
        chk("midrst_ac", 32'(ac), 32'h0);
        chk("midrst_cs", 32'(mem_cs), 32'd0);
        chk("midrst_we", 32'(mem_we), 32'd0);
        chk("midrst_addr", 32'(mem_addr), 32'h0);
        chk("midrst_wdata", 32'(mem_wdata), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) cycle();
        chk("midrst_idle_cs", 32'(mem_cs), 32'd0);
        chk("midrst_idle_pc", 32'(pc), 32'h000);
        chk("midrst_no_write", 32'(we_cnt), 32'd0);

        // LOAD 0x00C
        do_reset();
        put(12'h000, 16'h100C);
        put(12'h001, 16'h7000);
        put(12'h00C, 16'h0007);
        go();
        run_until(1, 50);
        chk("load_ac", 32'(ac), 32'h0007);
        chk("load_pc", 32'(pc), 32'h001);
        run_until(1000, 50);
        repeat (3) cycle();
        chk("load_halt_pc", 32'(pc), 32'h002);

        // ADD/SUBT wrap boundaries
        do_reset();
        put(12'h000, 16'h1020);
        put(12'h001, 16'h3021);
        put(12'h002, 16'h2022);
        put(12'h003, 16'hA000);
        put(12'h004, 16'h4021);
        put(12'h005, 16'h2023);
        put(12'h006, 16'h7000);
        put(12'h020, 16'h7FFF);
        put(12'h021, 16'h0001);
        go();
        run_until(2, 50);
        chk("add_ac", 32'(ac), 32'h8000);
        run_until(1000, 100);
        repeat (2) cycle();
        chk("add_ram", 32'(ram[12'h022]), 32'h8000);
        chk("sub_ram", 32'(ram[12'h023]), 32'hFFFF);
        chk("sub_ac", 32'(ac), 32'hFFFF);

        // STORE 0x00E
        do_reset();
        put(12'h000, 16'h1024);
        put(12'h001, 16'h200E);
        put(12'h002, 16'h7000);
        put(12'h024, 16'h1234);
        go();
        run_until(1000, 60);
        repeat (2) cycle();
        chk("store_we_count", 32'(we_cnt), 32'd1);
        chk("store_addr", 32'(last_waddr), 32'h00E);
        chk("store_data", 32'(last_wdata), 32'h1234);
        chk("store_ram", 32'(ram[12'h00E]), 32'h1234);

        // SKIPCOND cases and wrap from the last address
        do_reset();
        put(12'h000, 16'hA000);
        put(12'h001, 16'h8400);
        put(12'h002, 16'h7000);
        put(12'h003, 16'h1020);
        put(12'h004, 16'h8000);
        put(12'h005, 16'h7000);
        put(12'h006, 16'h1021);
        put(12'h007, 16'h8800);
        put(12'h008, 16'h8C00);
        put(12'h009, 16'h9FFE);
        put(12'hFFE, 16'h8000);
        put(12'h020, 16'hFFFF);
        put(12'h021, 16'h8000);
        go();
        run_until(2, 50);
        chk("skip_eq_pc", 32'(pc), 32'h003);
        run_until(4, 50);
        chk("skip_lt_pc", 32'(pc), 32'h006);
        run_until(6, 50);
        chk("skip_gt_pc", 32'(pc), 32'h008);
        run_until(9, 50);
        chk("skip_wrap_pc", 32'(pc), 32'h000);

        // 5*7 by repeated ADD with an undefined opcode early on
        do_reset();
        put(12'h000, 16'hA000);
        put(12'h001, 16'h2022);
        put(12'h002, 16'h5000);
        put(12'h003, 16'h1022);
        put(12'h004, 16'h3021);
        put(12'h005, 16'h2022);
        put(12'h006, 16'h1020);
        put(12'h007, 16'h4023);
        put(12'h008, 16'h2020);
        put(12'h009, 16'h8400);
        put(12'h00A, 16'h9003);
        put(12'h00B, 16'h7000);
        put(12'h020, 16'h0005);
        put(12'h021, 16'h0007);
        put(12'h023, 16'h0001);
        go();
        run_until(100000, 400);
        repeat (6) cycle();
        chk("prog_result", 32'(ram[12'h022]), 32'h0023);
        chk("prog_illegal_cnt", 32'(illegal_cnt), 32'd1);
        chk("prog_halted", 32'(halted), 32'd1);
        chk("prog_pc", 32'(pc), 32'h00C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
